timer_irq_dev: RTL and testbench
================================

// Module: timer_irq_dev
// PURPOSE
//   Memory-mapped programmable down-counter timer that raises a hardware interrupt request line.
//   Sits on the peripheral bus as a slave; irq drives one bit of the CPU HWInt[5:0] vector into coprocessor 0.
//   Software programs PRESET and CTRL through sw.
//   It reads COUNT through lw.
//   It acknowledges a one-shot interrupt by rewriting CTRL or PRESET.
// PARAMETERS
//   W            32   counter/PRESET width in bits (rd/wd stay 32 bits; COUNT/PRESET zero-extended on read)
// PORTS
//   clk     in   1   clock; all state updates on posedge
//   reset   in   1   synchronous, active-high reset
//   addr    in   2   word offset: 0=CTRL, 1=PRESET, 2=COUNT (read-only), 3=reserved
//   we      in   1   write strobe, sampled on posedge
//   wd      in   32  write data
//   rd      out  32  read data, combinational from addr
//   irq     out  1   interrupt request to CPU HWInt bit
// BEHAVIOUR
//   Registers
//   - CTRL[0] EN (enable).
//   - CTRL[2:1] MODE: 00 one-shot, 01 auto-reload, 1x treated as 00.
//   - CTRL[3] IM (irq mask, 1=permit).
//   - CTRL[31:4] read 0.
//   - PRESET[W-1:0] read/write.
//   - COUNT[W-1:0] read-only.
//   Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, irq=0.
//   rd
//   - addr0 gives {28'b0, CTRL[3:0]}; addr1 gives PRESET; addr2 gives COUNT; addr3 gives 0.
//   - No read side effects.
//   Writes (we=1)
//   - addr0 sets CTRL[3:0]<=wd[3:0].
//   - addr1 sets PRESET<=wd[W-1:0].
//   - addr2 and addr3 are ignored.
//   FSM (state register, one transition per clk)
//   - IDLE: EN=1 -> LOAD; else stay; COUNT holds.
//   - LOAD: COUNT<=PRESET -> CNT.
//   - CNT: EN=0 -> IDLE (COUNT frozen).
//     Else if COUNT>1, COUNT<=COUNT-1.
//     Else (COUNT<=1), COUNT<=0, irq_flag<=1 -> INT.
//   - INT: in MODE one-shot, hardware clears CTRL.EN -> IDLE.
//     In MODE auto-reload -> LOAD.
//   FSM decisions use the register values before the edge.
//   A CTRL write at edge t is first seen by the FSM at edge t+1.
//   irq and acknowledge
//   - irq = irq_flag & CTRL.IM; registered flag, no combinational path from wd.
//   - One-shot: irq_flag holds until any write to CTRL or PRESET (acknowledge), then clears on that edge.
//   - Auto-reload: irq_flag clears on the edge leaving INT, giving a 1-cycle pulse per period.
//   Latency
//   - Enable write at edge 0 with PRESET=N (N>=1) gives LOAD at edge 1 and COUNT=N at edge 2.
//   - COUNT=0, INT and irq=1 follow at edge N+2.
//   - PRESET=0 behaves as PRESET=1.
//   - Auto-reload period is N+2 cycles.
//   Boundary and simultaneous events
//   - irq_flag set and ack write on the same edge: set wins.
//   - Hardware EN-clear in INT and a software CTRL write on the same edge: the software value wins.
//   - A PRESET write during CNT takes effect at the next LOAD only.
//   - A CTRL write keeping EN=1 during CNT does not restart the count; a MODE change applies at the next INT.
//   - A CTRL write with EN=0 during CNT still allows the decrement on that edge, then goes IDLE with COUNT frozen.
//   - Re-enabling from IDLE always reloads PRESET; there is no resume.
//   - Counting is down only with no wrap: COUNT never underflows below 0.
//   - With IM=0 the count and state behave identically and irq_flag is still set.
//   - Setting IM later raises irq immediately if irq_flag is still set.
//   - reset mid-operation: all registers return to reset values at that edge and irq=0 the following cycle.
// TESTING
//   1 One-shot
//     - Stimulus: PRESET=3, then CTRL=4'b1001 at edge 0.
//     - Response: COUNT reads 3,2,1,0 at edges 2..5 and irq=1 from edge 5, held.
//     - CTRL then reads 4'b1000; writing CTRL=0 drops irq at the next edge.
//   2 Auto-reload
//     - Stimulus: PRESET=2, CTRL=4'b1011.
//     - Response: irq is a 1-cycle pulse with period 4; first pulse at edge 4; EN stays 1.
//   3 Masked
//     - Stimulus: PRESET=3, CTRL=4'b0001.
//     - Response: irq stays 0; COUNT=0 and EN=0 by edge 5.
//     - Then write CTRL=4'b1000 (a CTRL write, so it acknowledges).
//     - Required: irq stays 0, because the ack clears irq_flag on the same edge IM is set.
//   4 Disable mid-count
//     - Stimulus: PRESET=10, enable, then write CTRL=4'b1000 in the cycle COUNT reads 6.
//     - Response: COUNT becomes 5 and stays 5, state IDLE, irq=0.
//     - Re-enabling reloads 10.
//   5 Reset mid-count
//     - Stimulus: PRESET=8, enable, assert reset at COUNT=4.
//     - Response: CTRL, PRESET and COUNT all read 0 and irq=0 after the edge.
//   6 Edge cases
//     - PRESET=0 with CTRL=4'b1001: irq=1 at edge 3.
//     - Ack write on the same edge as the set: irq_flag remains 1.

Source files
------------

// File: rtl/timer_irq_dev.sv
// ---------------------------------------------------------------------------
// timer_irq_dev
//   Memory-mapped programmable down-counter timer with an interrupt request
//   output. Software programs PRESET and CTRL, reads COUNT back, and
//   acknowledges a one-shot interrupt by rewriting CTRL or PRESET. irq feeds
//   one bit of the CPU hardware interrupt vector.
//
//   Register map (word offset on addr):
//     0  CTRL    [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x = 00),
//                [3] IM (1 = irq permitted), [31:4] read as 0
//     1  PRESET  [W-1:0] read/write, zero-extended on read
//     2  COUNT   [W-1:0] read-only, zero-extended on read
//     3  reserved, reads 0, writes ignored
//
// Ports
//   clk    in   1   clock, all state changes on posedge
//   reset  in   1   synchronous, active-high reset
//   addr   in   2   register word offset
//   we     in   1   write strobe, sampled on posedge
//   wd     in   32  write data
//   rd     out  32  read data, combinational from addr, no side effects
//   irq    out  1   interrupt request (irqFlag gated by CTRL.IM)
//
// Parameter
//   W  counter / PRESET width in bits, 1..32
// ---------------------------------------------------------------------------
module timer_irq_dev #(
  parameter int W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  typedef enum logic [1:0] {
    sIdle = 2'd0,
    sLoad = 2'd1,
    sCnt  = 2'd2,
    sInt  = 2'd3
  } state_t;

  localparam logic [W-1:0] ONE = W'(1);

  state_t       state;
  logic [3:0]   ctrl;
  logic [W-1:0] preset;
  logic [W-1:0] count;
  logic         irqFlag;

  logic ctrlEn;
  logic ctrlIm;
  logic autoReload;
  logic ctrlWr;
  logic presetWr;

  assign ctrlEn     = ctrl[0];
  assign ctrlIm     = ctrl[3];
  // Only MODE=01 reloads; 10 and 11 fall back to one-shot behaviour.
  assign autoReload = (ctrl[2:1] == 2'b01);
  assign ctrlWr     = we && (addr == 2'd0);
  assign presetWr   = we && (addr == 2'd1);

  // irq is the AND of two registers, so there is no path from wd to irq.
  assign irq = irqFlag & ctrlIm;

  // Register read mux
  always_comb begin
    rd = 32'd0;
    case (addr)
      2'd0:    rd = {28'd0, ctrl};
      2'd1:    rd = 32'(preset);
      2'd2:    rd = 32'(count);
      default: rd = 32'd0;
    endcase
  end

  // Control FSM, counter and register file.
  // Statement order inside the clocked block encodes the priority rules:
  //   - the acknowledge clear of irqFlag comes before the FSM so that a
  //     same-edge set from the counter wins;
  //   - the software CTRL write comes after the FSM so that it overrides the
  //     hardware EN clear on leaving INT in one-shot mode.
  // Every FSM decision reads the pre-edge register values, so a CTRL write is
  // first seen by the FSM one edge after it lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= sIdle;
      ctrl    <= 4'd0;
      preset  <= '0;
      count   <= '0;
      irqFlag <= 1'b0;
    end else begin
      if (presetWr) begin
        preset <= wd[W-1:0];
      end

      // Any CTRL or PRESET write acknowledges a pending interrupt.
      if (ctrlWr || presetWr) begin
        irqFlag <= 1'b0;
      end

      case (state)
        sIdle: begin
          // Always restarts from PRESET; COUNT is never resumed.
          if (ctrlEn) begin
            state <= sLoad;
          end
        end

        sLoad: begin
          count <= preset;
          state <= sCnt;
        end

        sCnt: begin
          if (!ctrlEn) begin
            state <= sIdle;
          end else if (count > ONE) begin
            count <= count - ONE;
          end else begin
            // COUNT of 0 or 1 terminates; PRESET=0 therefore acts as 1 and
            // the counter never wraps below zero.
            count   <= '0;
            irqFlag <= 1'b1;
            state   <= sInt;
          end
        end

        sInt: begin
          if (autoReload) begin
            // Auto-reload produces a single-cycle irq pulse per period.
            irqFlag <= 1'b0;
            state   <= sLoad;
          end else begin
            ctrl[0] <= 1'b0;
            state   <= sIdle;
          end
        end

        default: begin
          state <= sIdle;
        end
      endcase

      if (ctrlWr) begin
        ctrl <= wd[3:0];
      end
    end
  end

endmodule

// File: tb/tb_timer_irq_dev.sv
module tb_timer_irq_dev;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  timer_irq_dev #(.W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wd    (wd),
    .rd    (rd),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per clock edge: optional write on that edge, then a read of
  // raddr and the irq level expected just after the edge.
  typedef struct {
    logic        doWr;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] expRd;
    logic        expIrq;
  } vec_t;

  vec_t vecs[$];

  task automatic addV(input logic doWr, input logic [1:0] waddr,
                      input logic [31:0] wdata, input logic [1:0] raddr,
                      input logic [31:0] expRd, input logic expIrq);
    vec_t v;
    v.doWr = doWr; v.waddr = waddr; v.wdata = wdata;
    v.raddr = raddr; v.expRd = expRd; v.expIrq = expIrq;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    wd   = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic chkRd(input string nm, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    checks++;
    if (rd !== exp) begin
      failures++;
      $display("FAIL %s: rd=%0h expected %0h", nm, rd, exp);
    end
  endtask

  task automatic chkIrq(input string nm, input logic exp);
    #1;
    checks++;
    if (irq !== exp) begin
      failures++;
      $display("FAIL %s: irq=%b expected %b", nm, irq, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    addr  = 2'd0;
    wd    = 32'd0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    chkRd("reset ctrl", 2'd0, 32'd0);
    chkRd("reset preset", 2'd1, 32'd0);
    chkRd("reset count", 2'd2, 32'd0);
    chkRd("reset rsvd", 2'd3, 32'd0);
    chkIrq("reset irq", 1'b0);

    // One-shot, PRESET=3, enable with IM at edge 0
    addV(1, 2'd1, 32'd3,   2'd1, 32'd3, 0);
    addV(1, 2'd0, 32'h9,   2'd0, 32'h9, 0);  // edge 0
    addV(0, 2'd0, 32'd0,   2'd2, 32'd0, 0);  // edge 1 LOAD
    addV(0, 2'd0, 32'd0,   2'd2, 32'd3, 0);  // edge 2
    addV(0, 2'd0, 32'd0,   2'd2, 32'd2, 0);
    addV(0, 2'd0, 32'd0,   2'd2, 32'd1, 0);
    addV(0, 2'd0, 32'd0,   2'd2, 32'd0, 1);  // edge 5 INT
    addV(0, 2'd0, 32'd0,   2'd0, 32'h8, 1);  // EN cleared, irq held
    addV(0, 2'd0, 32'd0,   2'd2, 32'd0, 1);
    addV(1, 2'd0, 32'd0,   2'd0, 32'd0, 0);  // ack
    addV(1, 2'd2, 32'd55,  2'd2, 32'd0, 0);  // COUNT read-only
    addV(1, 2'd3, 32'hff,  2'd3, 32'd0, 0);  // reserved
    // Auto-reload, PRESET=2, period 4
    addV(1, 2'd1, 32'd2,   2'd1, 32'd2, 0);
    addV(1, 2'd0, 32'hB,   2'd0, 32'hB, 0);  // edge 0
    addV(0, 2'd0, 32'd0,   2'd2, 32'd0, 0);
    addV(0, 2'd0, 32'd0,   2'd2, 32'd2, 0);
    addV(0, 2'd0, 32'd0,   2'd2, 32'd1, 0);
    addV(0, 2'd0, 32'd0,   2'd2, 32'd0, 1);  // edge 4 pulse
    addV(0, 2'd0, 32'd0,   2'd2, 32'd0, 0);
    addV(0, 2'd0, 32'd0,   2'd2, 32'd2, 0);
    addV(0, 2'd0, 32'd0,   2'd2, 32'd1, 0);
    addV(0, 2'd0, 32'd0,   2'd2, 32'd0, 1);  // edge 8 pulse
    addV(0, 2'd0, 32'd0,   2'd0, 32'hB, 0);  // EN stays 1
    addV(1, 2'd0, 32'd0,   2'd0, 32'd0, 0);  // disable during LOAD
    addV(0, 2'd0, 32'd0,   2'd2, 32'd2, 0);
    addV(0, 2'd0, 32'd0,   2'd2, 32'd2, 0);
    // Masked one-shot, PRESET=3, CTRL=0001
    addV(1, 2'd1, 32'd3,   2'd1, 32'd3, 0);
    addV(1, 2'd0, 32'h1,   2'd0, 32'h1, 0);  // edge 0
    addV(0, 2'd0, 32'd0,   2'd2, 32'd2, 0);  // edge 1, old COUNT
    addV(0, 2'd0, 32'd0,   2'd2, 32'd3, 0);
    addV(0, 2'd0, 32'd0,   2'd2, 32'd2, 0);
    addV(0, 2'd0, 32'd0,   2'd2, 32'd1, 0);
    addV(0, 2'd0, 32'd0,   2'd2, 32'd0, 0);  // edge 5, masked
    addV(0, 2'd0, 32'd0,   2'd0, 32'h0, 0);  // EN cleared
    addV(1, 2'd0, 32'h8,   2'd0, 32'h8, 0);  // IM set + ack
    addV(0, 2'd0, 32'd0,   2'd0, 32'h8, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].doWr) wr(vecs[i].waddr, vecs[i].wdata);
      else step();
      chkRd($sformatf("vec%0d rd", i), vecs[i].raddr, vecs[i].expRd);
      chkIrq($sformatf("vec%0d irq", i), vecs[i].expIrq);
    end

    // Disable mid-count, then re-enable reloads PRESET
    doReset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    for (int i = 0; i < 6; i++) step();
    chkRd("dis count6", 2'd2, 32'd6);
    wr(2'd0, 32'h8);
    chkRd("dis count5", 2'd2, 32'd5);
    step();
    chkRd("dis frozen", 2'd2, 32'd5);
    step();
    chkRd("dis frozen2", 2'd2, 32'd5);
    chkIrq("dis irq", 1'b0);
    wr(2'd0, 32'h9);
    step();
    step();
    chkRd("reen reload", 2'd2, 32'd10);
    wr(2'd1, 32'd7);
    chkRd("preset in cnt", 2'd2, 32'd9);
    chkRd("preset value", 2'd1, 32'd7);

    // Reset mid-count
    doReset();
    wr(2'd1, 32'd8);
    wr(2'd0, 32'h9);
    for (int i = 0; i < 6; i++) step();
    chkRd("rst count4", 2'd2, 32'd4);
    doReset();
    chkRd("rst ctrl", 2'd0, 32'd0);
    chkRd("rst preset", 2'd1, 32'd0);
    chkRd("rst count", 2'd2, 32'd0);
    chkIrq("rst irq", 1'b0);
    step();
    chkRd("rst count hold", 2'd2, 32'd0);

    // PRESET=0 behaves as 1: irq at edge 3
    doReset();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    step();
    chkIrq("p0 e1", 1'b0);
    step();
    chkIrq("p0 e2", 1'b0);
    step();
    chkIrq("p0 e3", 1'b1);

    // Ack on the same edge as the set: set wins
    doReset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    for (int i = 0; i < 4; i++) step();
    wr(2'd1, 32'd3);
    chkIrq("ackset e5", 1'b1);
    step();
    chkIrq("ackset e6", 1'b1);
    chkRd("ackset ctrl", 2'd0, 32'h8);

    // Software CTRL write beats hardware EN clear in INT
    doReset();
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    step();
    step();
    chkRd("sw e2 count", 2'd2, 32'd1);
    step();
    chkIrq("sw e3 irq", 1'b1);
    wr(2'd0, 32'h9);
    chkRd("sw wins ctrl", 2'd0, 32'h9);
    chkIrq("sw ack irq", 1'b0);
    step();
    step();
    chkIrq("sw e6 irq", 1'b0);
    step();
    chkIrq("sw e7 irq", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
